// File: rtl/gain_stereo_sched.sv
// Shares one signed volume multiplier between left/right channels, popping input
// FIFOs in strict L,R order and pushing saturated results to the matching output FIFO.
module gain_stereo_sched #(
    parameter int DATA_SIZE = 32,
    parameter int VOL_WIDTH = 10,
    parameter int FRAC_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [VOL_WIDTH-1:0] volume,
    input  logic                 left_in_empty,
    output logic                 left_in_rd_en,
    input  logic [DATA_SIZE-1:0] left_in_dout,
    input  logic                 right_in_empty,
    output logic                 right_in_rd_en,
    input  logic [DATA_SIZE-1:0] right_in_dout,
    input  logic                 left_out_full,
    output logic                 left_out_wr_en,
    output logic [DATA_SIZE-1:0] left_out_din,
    input  logic                 right_out_full,
    output logic                 right_out_wr_en,
    output logic [DATA_SIZE-1:0] right_out_din,
    output logic [31:0]          pair_count,
    output logic                 busy,
    output logic                 clipped
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT_L = 2'd1;
    localparam logic [1:0] WAIT_R = 2'd2;
    localparam int PW = DATA_SIZE + VOL_WIDTH + 1;

    logic [1:0]           r_state, w_state_nxt;
    logic [VOL_WIDTH-1:0] r_vol_pair;
    logic                 r_s1_valid, r_s1_ch;
    logic [DATA_SIZE-1:0] r_s1_data;
    logic [VOL_WIDTH-1:0] r_s1_vol;
    logic                 r_s2_valid, r_s2_ch;
    logic [DATA_SIZE-1:0] r_s2_data;
    logic [31:0]          r_pair_count;
    logic                 r_clipped;

    logic                 w_dest_full, w_adv, w_issue_l, w_issue_r;
    logic signed [PW-1:0] w_prod, w_shift;
    logic                 w_ovf;
    logic [DATA_SIZE-1:0] w_sat;

    // S2 channel tag: 0 = left, 1 = right
    assign w_dest_full = r_s2_ch ? right_out_full : left_out_full;
    assign w_adv       = ~r_s2_valid | ~w_dest_full;
    assign w_issue_l   = (r_state == WAIT_L) & enable & ~left_in_empty & w_adv;
    assign w_issue_r   = (r_state == WAIT_R) & ~right_in_empty & w_adv;

    // Both operands extended to the full product width; the true product always fits.
    assign w_prod  = {{(VOL_WIDTH+1){r_s1_data[DATA_SIZE-1]}}, r_s1_data}
                   * {{DATA_SIZE{1'b0}}, 1'b0, r_s1_vol};
    assign w_shift = w_prod >>> FRAC_BITS;
    assign w_ovf   = ~(&w_shift[PW-1:DATA_SIZE-1]) & (|w_shift[PW-1:DATA_SIZE-1]);
    assign w_sat   = w_ovf ? (w_shift[PW-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                            : {1'b0, {(DATA_SIZE-1){1'b1}}})
                           : w_shift[DATA_SIZE-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (enable) w_state_nxt = WAIT_L;
            WAIT_L: begin
                if (!enable)        w_state_nxt = IDLE;
                else if (w_issue_l) w_state_nxt = WAIT_R;
            end
            WAIT_R:  if (w_issue_r) w_state_nxt = enable ? WAIT_L : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_vol_pair   <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_ch      <= 1'b0;
            r_s1_data    <= '0;
            r_s1_vol     <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_ch      <= 1'b0;
            r_s2_data    <= '0;
            r_pair_count <= '0;
            r_clipped    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue_l) r_vol_pair   <= volume;
            if (w_issue_r) r_pair_count <= r_pair_count + 32'd1;
            if (w_adv) begin
                r_s2_valid <= r_s1_valid;
                r_s2_ch    <= r_s1_ch;
                if (r_s1_valid) begin
                    r_s2_data <= w_sat;
                    if (w_ovf) r_clipped <= 1'b1;
                end
                r_s1_valid <= w_issue_l | w_issue_r;
                r_s1_ch    <= w_issue_r;
                if (w_issue_l | w_issue_r) begin
                    r_s1_data <= w_issue_l ? left_in_dout : right_in_dout;
                    r_s1_vol  <= w_issue_l ? volume : r_vol_pair;
                end
            end
        end
    end

    assign left_in_rd_en   = w_issue_l;
    assign right_in_rd_en  = w_issue_r;
    assign left_out_wr_en  = r_s2_valid & ~r_s2_ch & ~left_out_full;
    assign right_out_wr_en = r_s2_valid &  r_s2_ch & ~right_out_full;
    assign left_out_din    = r_s2_data;
    assign right_out_din   = r_s2_data;
    assign pair_count      = r_pair_count;
    assign busy            = (r_state != IDLE) | r_s1_valid | r_s2_valid;
    assign clipped         = r_clipped;

endmodule

// File: doc/gain_stereo_sched.md
Name: gain_stereo_sched

Overview:
Sequencer and arbiter that shares one signed volume-gain multiplier between the left and right audio channels at the tail of the FM receiver chain, after the de-emphasis IIRs. It pops samples from the two channel input FIFOs in strict L,R alternation so stereo pairs stay aligned, and pushes scaled, saturated results to the matching output FIFO. Volume is latched once per stereo pair.

Parameters:
DATA_SIZE, 32, sample width (signed two's complement)
VOL_WIDTH, 10, volume word width (unsigned)
FRAC_BITS, 8, volume fraction bits; unity gain = 2^FRAC_BITS

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  run request
volume  in  VOL_WIDTH  unsigned gain, latched at each left issue
left_in_empty  in  1  left input FIFO empty (first-word-fall-through)
left_in_rd_en  out  1  pop left input; dout is valid in the same cycle
left_in_dout  in  DATA_SIZE  left sample
right_in_empty  in  1  right input FIFO empty
right_in_rd_en  out  1  pop right input
right_in_dout  in  DATA_SIZE  right sample
left_out_full  in  1  left output FIFO full
left_out_wr_en  out  1  push left result
left_out_din  out  DATA_SIZE  left result
right_out_full  in  1  right output FIFO full
right_out_wr_en  out  1  push right result
right_out_din  out  DATA_SIZE  right result
pair_count  out  32  stereo pairs issued; wraps 2^32-1 -> 0
busy  out  1  state != IDLE, or S1 or S2 valid
clipped  out  1  sticky: set on any saturation; cleared only by reset

Behaviour:
- Reset (reset=0, async): state=IDLE, S1/S2 valid=0, all rd_en/wr_en=0, din outputs=0, pair_count=0, clipped=0, busy=0. In-flight samples are discarded. Reset must not be applied mid-pair in system use; if it is, output FIFOs may end up holding an unmatched left sample.
- Pipeline: S1 holds operand, volume and channel tag. S2 holds result and channel tag. The multiply, shift and saturate logic sits between S1 and S2.
- Stall: adv = !S2_valid | !full(S2 destination). When adv=1, S2<=S1 and S1<=issue (or bubble). When adv=0, S1 and S2 hold.
- Output: the wr_en of the S2 destination = S2_valid & !full(dest); din = S2 result. The other channel's wr_en=0.
- Latency: rd_en in cycle t -> wr_en in cycle t+2 with no backpressure. Throughput is 1 sample/cycle (one pair per 2 cycles).
- FSM:
  - IDLE: enable=1 -> WAIT_L.
  - WAIT_L:
    - enable=0 -> IDLE, no issue.
    - else if !left_in_empty & adv: left_in_rd_en=1, latch volume into vol_pair, -> WAIT_R.
  - WAIT_R (enable ignored):
    - if !right_in_empty & adv: right_in_rd_en=1, issue with vol_pair, pair_count++.
    - then -> WAIT_L if enable=1, else IDLE.
- At most one rd_en is high per cycle. rd_en is never high when the FIFO is empty or adv=0. A right sample is never popped before its left partner.
- Arithmetic:
  - p = x * signed({0,vol}), width DATA_SIZE+VOL_WIDTH+1.
  - q = p >>> FRAC_BITS (arithmetic, floor).
  - Saturate q to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1]; any saturation sets clipped.
  - vol=0 -> output 0.
- Changes to volume during WAIT_R do not affect the pending right sample.
- Simultaneous: output full with a new input available -> no issue that cycle (adv=0). Entering IDLE with S1/S2 valid: the pipeline still drains; busy stays high until empty.

Test Plan:
- Unity: volume=256, L=0x00001234, R=0xFFFFEDCC -> left_out 0x00001234, right_out 0xFFFFEDCC, wr_en 2 cycles after each rd_en, pair_count=1.
- Scaling/rounding: volume=128, L=0xFFFFFF00, R=0xFFFFFFFD -> 0xFFFFFF80, 0xFFFFFFFE (floor). Volume=0 -> both outputs 0x00000000.
- Saturation: volume=512, L=0x40000000, R=0xC0000000 -> 0x7FFFFFFF, 0x80000000; clipped=1 and stays 1 after later in-range samples.
- Alternation/pair volume: right FIFO holds 4 samples, left empty -> no right_in_rd_en. Volume changes 256->512 between L and R issue -> both samples of the pair use 256.
- Backpressure: hold left_out_full=1 for 10 cycles during 1000-pair stream -> no left write, no rd_en while stalled, no loss or duplication. Output matches golden; pair_count=1000.
- Enable/reset: drop enable in WAIT_R -> right still issued, then IDLE, busy falls after drain. Assert reset=0 mid-stream -> all outputs 0 immediately, pair_count=0.
